// File: rtl/fixed_to_float_normaliser.sv
// Converts a signed fixed-point word into an IEEE-754 single-precision value.
// A leading-zero normaliser shifts one bit per cycle, then packs the result. Only one conversion is in flight.
module fixed_to_float_normaliser #(
    parameter int INTEGER_WIDTH    = 4,
    parameter int FRACTIONAL_WIDTH = 20,
    parameter int FIXED_WIDTH      = INTEGER_WIDTH + FRACTIONAL_WIDTH,
    parameter int FLOAT_WIDTH      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FIXED_WIDTH-1:0] in_fixed,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FLOAT_WIDTH-1:0] out_float,
    output logic                   busy
);

    if (FIXED_WIDTH > 24) begin : g_fixed_width_check
        $error("fixed_to_float_normaliser: FIXED_WIDTH must be <= 24");
    end
    if (FLOAT_WIDTH != 32) begin : g_float_width_check
        $error("fixed_to_float_normaliser: FLOAT_WIDTH must be 32");
    end

    localparam int K_WIDTH = ($clog2(FIXED_WIDTH) > 5) ? $clog2(FIXED_WIDTH) : 5;
    localparam logic [K_WIDTH-1:0] K_ONE = 1;
    // Exponent when the leading one already sits in the top bit (k == 0).
    localparam logic [7:0] EXP_BASE = 8'(127 + FIXED_WIDTH - 1 - FRACTIONAL_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                 state;
    logic                   sign;
    logic [FIXED_WIDTH-1:0] mag;
    logic [K_WIDTH-1:0]     k;

    logic [FIXED_WIDTH-1:0] in_mag;
    logic [7:0]             exp_val;
    logic [22:0]            mant;

    // The most negative input negates to 2^(W-1), which is still correct as an unsigned magnitude.
    assign in_mag  = in_fixed[FIXED_WIDTH-1] ? -in_fixed : in_fixed;
    assign exp_val = EXP_BASE - 8'(k);

    if (FIXED_WIDTH == 24) begin : g_mant_full
        assign mant = mag[22:0];
    end else begin : g_mant_pad
        assign mant = {mag[FIXED_WIDTH-2:0], {(24 - FIXED_WIDTH){1'b0}}};
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sign      <= 1'b0;
            mag       <= '0;
            k         <= '0;
            out_valid <= 1'b0;
            out_float <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_fixed == '0) begin
                            out_float <= '0;
                            out_valid <= 1'b1;
                            state     <= OUT;
                        end else begin
                            sign  <= in_fixed[FIXED_WIDTH-1];
                            mag   <= in_mag;
                            k     <= '0;
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (mag[FIXED_WIDTH-1]) begin
                        out_float <= {sign, exp_val, mant};
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        mag <= mag << 1;
                        k   <= k + K_ONE;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
